// File: rtl/div255_arb_seq.sv
// Two-requester arbiter and byte-serial sequencer for an exact divide-by-255 (y*255 == x), one byte per clock.
// Optional macro DIV255_EXACT_CHK_EN adds the inexact flag and keeps the original operand for the check.
module div255_arb_seq #(
  parameter int WIDTH      = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] x1,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] y,
  output logic             busy
`ifdef DIV255_EXACT_CHK_EN
  ,
  output logic             inexact
`endif
);

  localparam int NB = WIDTH / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_n;
  logic [WIDTH-1:0] r_y;
  logic             r_valid;
  logic             r_id;
  logic             r_rr;

  logic             w_gnt;
  logic             w_req_any;
  logic [WIDTH-1:0] w_op;
  logic [WIDTH-1:0] w_ysh;
  logic [7:0]       w_prev;
  logic [7:0]       w_nbyte;
  logic             w_cin;
  logic [8:0]       w_sum;
  logic [WIDTH-1:0] w_y_next;
  logic             w_last;

  // A lone request wins outright; the pointer only breaks ties.
  always_comb begin
    w_gnt = 1'b0;
    if (req_valid == 2'b10)
      w_gnt = 1'b1;
    else if (req_valid == 2'b11)
      w_gnt = FIXED_PRIO ? 1'b0 : r_rr;
  end

  assign w_req_any = |req_valid;
  assign req_ready = (r_state == IDLE && w_req_any) ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;
  assign w_op      = w_gnt ? x1 : x0;

  // Byte i adds the previous quotient byte, so y accumulates as y = (y<<8) + n.
  assign w_ysh = r_y << 8;
  assign w_cin = (r_cnt == '0) ? 1'b0 : r_carry;

  always_comb begin
    w_prev   = 8'h00;
    w_nbyte  = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (r_cnt == CW'(i)) begin
        w_prev  = w_ysh[8*i +: 8];
        w_nbyte = r_n[8*i +: 8];
      end
    end
  end

  assign w_sum  = {1'b0, w_prev} + {1'b0, w_nbyte} + {8'h00, w_cin};
  assign w_last = (r_cnt == CW'(NB - 1));

  always_comb begin
    w_y_next = r_y;
    for (int i = 0; i < NB; i++) begin
      if (r_cnt == CW'(i))
        w_y_next[8*i +: 8] = w_sum[7:0];
    end
  end

`ifdef DIV255_EXACT_CHK_EN
  logic [WIDTH-1:0] r_x;
  logic             r_inexact;
  logic [WIDTH+7:0] w_prod;

  // Product kept 8 bits wider: a quotient whose y*255 overflows WIDTH means x was not a multiple of 255.
  assign w_prod  = ({8'h00, w_y_next} << 8) - {8'h00, w_y_next};
  assign inexact = r_inexact;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_n     <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      r_id    <= 1'b0;
      r_rr    <= 1'b0;
`ifdef DIV255_EXACT_CHK_EN
      r_x       <= '0;
      r_inexact <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req_any) begin
            r_n     <= ~w_op + WIDTH'(1);
            r_id    <= w_gnt;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_state <= CALC;
`ifdef DIV255_EXACT_CHK_EN
            r_x <= w_op;
`endif
          end
        end
        CALC: begin
          r_y     <= w_y_next;
          r_carry <= w_sum[8];
          if (w_last) begin
            r_valid <= 1'b1;
            r_state <= DONE;
`ifdef DIV255_EXACT_CHK_EN
            r_inexact <= (w_prod != {8'h00, r_x});
`endif
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          if (resp_ready) begin
            r_valid <= 1'b0;
            r_rr    <= ~r_id;
            r_state <= IDLE;
`ifdef DIV255_EXACT_CHK_EN
            r_inexact <= 1'b0;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign resp_valid = r_valid;
  assign resp_id    = r_id;
  assign y          = r_y;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_div255_arb_seq.sv
// Directed bench for div255_arb_seq: single ops, arbitration, response stall, async reset mid-op.
module tb_div255_arb_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] x0, x1;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_id;
  logic [31:0] y;
  logic        busy;
`ifdef DIV255_EXACT_CHK_EN
  logic        inexact;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div255_arb_seq #(.WIDTH(32), .FIXED_PRIO(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .x0         (x0),
    .x1         (x1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .y          (y),
    .busy       (busy)
`ifdef DIV255_EXACT_CHK_EN
    ,
    .inexact    (inexact)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Waits at negedges for resp_valid; returns number of negedges waited (bounded).
  task automatic wait_resp(output int lat);
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input logic sel, input logic [31:0] x, input logic [31:0] ey, input string tag);
    int lat;
    @(negedge clk);
    if (sel) begin req_valid = 2'b10; x1 = x; end
    else     begin req_valid = 2'b01; x0 = x; end
    #1 check({tag, "_rdy"}, {30'b0, req_ready}, sel ? 32'd2 : 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    x0 = 32'hDEAD_BEEF;
    x1 = 32'hDEAD_BEEF;
    wait_resp(lat);
    check({tag, "_lat"}, lat, 32'd4);
    check({tag, "_y"}, y, ey);
    check({tag, "_id"}, {31'b0, resp_id}, {31'b0, sel});
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, "_vld_clr"}, {31'b0, resp_valid}, 32'd0);
    check({tag, "_idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    rst = 1'b0;
    req_valid = 2'b00;
    resp_ready = 1'b0;
    x0 = '0;
    x1 = '0;
    #12;
    check("rst_vld",  {31'b0, resp_valid}, 32'd0);
    check("rst_y",    y, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_id",   {31'b0, resp_id}, 32'd0);
    check("rst_rdy",  {30'b0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    run_op(1'b0, 32'd255,        32'h0000_0001, "x0_255");
    run_op(1'b1, 32'hFFFF_FFFF,  32'h0101_0101, "x1_ffff");
    run_op(1'b0, 32'd0,          32'h0000_0000, "x0_zero");
    run_op(1'b0, 32'd510,        32'h0000_0002, "x0_510");
    run_op(1'b0, 32'd256,        32'hFEFE_FF00, "x0_256");

    // Reset clears the rr pointer, then both request together.
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b11;
    x0 = 32'd255;
    x1 = 32'd765;
    resp_ready = 1'b1;
    #1 check("rr_first_rdy", {30'b0, req_ready}, 32'd1);
    @(negedge clk);
    wait_resp(lat);
    check("rr_first_lat", lat, 32'd4);
    check("rr_first_id", {31'b0, resp_id}, 32'd0);
    check("rr_first_y", y, 32'd1);
    @(negedge clk);
    check("rr_second_rdy", {30'b0, req_ready}, 32'd2);
    @(negedge clk);
    wait_resp(lat);
    check("rr_second_id", {31'b0, resp_id}, 32'd1);
    check("rr_second_y", y, 32'd3);
    req_valid = 2'b00;
    @(negedge clk);
    resp_ready = 1'b0;
    check("rr_done_idle", {31'b0, busy}, 32'd0);

    // Response stall with a pending request.
    @(negedge clk);
    req_valid = 2'b01;
    x0 = 32'd765;
    @(negedge clk);
    x0 = 32'd255;
    wait_resp(lat);
    check("stall_lat", lat, 32'd4);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("stall_vld",  {31'b0, resp_valid}, 32'd1);
      check("stall_y",    y, 32'd3);
      check("stall_id",   {31'b0, resp_id}, 32'd0);
      check("stall_rdy",  {30'b0, req_ready}, 32'd0);
      check("stall_busy", {31'b0, busy}, 32'd1);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("stall_release_vld",  {31'b0, resp_valid}, 32'd0);
    check("stall_release_busy", {31'b0, busy}, 32'd0);
    check("stall_release_rdy",  {30'b0, req_ready}, 32'd1);
    req_valid = 2'b00;

    // Async reset during the second CALC cycle.
    @(negedge clk);
    req_valid = 2'b01;
    x0 = 32'd510;
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    check("arst_busy", {31'b0, busy}, 32'd0);
    check("arst_y",    y, 32'd0);
    check("arst_vld",  {31'b0, resp_valid}, 32'd0);
    check("arst_id",   {31'b0, resp_id}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("arst_hold_vld", {31'b0, resp_valid}, 32'd0);
    end
    rst = 1'b1;
    run_op(1'b0, 32'd255, 32'h0000_0001, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
